// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-master round-robin arbiter in front of a single-port RAM
// Grants are registered; address/data/strobe muxing toward the RAM is combinational.
module ram_arbiter #(
  parameter int address_width = 16,
  parameter int data_width    = 8,
  parameter int max_burst     = 4,
  parameter int burst_width   = 3
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     req_a,
  input  logic                     lock_a,
  input  logic                     we_a,
  input  logic [address_width-1:0] addr_a,
  input  logic [data_width-1:0]    wdata_a,
  output logic                     gnt_a,
  input  logic                     req_b,
  input  logic                     lock_b,
  input  logic                     we_b,
  input  logic [address_width-1:0] addr_b,
  input  logic [data_width-1:0]    wdata_b,
  output logic                     gnt_b,
  output logic [data_width-1:0]    rdata,
  output logic [address_width-1:0] ram_address,
  output logic [data_width-1:0]    ram_wdata,
  input  logic [data_width-1:0]    ram_rdata,
  output logic                     ram_in,
  output logic                     ram_out
);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

  localparam logic [burst_width-1:0] BURST_LAST = burst_width'(max_burst - 1);

  state_t                 r_state;
  state_t                 w_next;
  logic                   r_last_b;
  logic [burst_width-1:0] r_burst;
  logic                   r_gnt_a;
  logic                   r_gnt_b;
  logic                   w_xfer_a;
  logic                   w_xfer_b;
  logic                   w_burst_done;

  assign gnt_a = r_gnt_a;
  assign gnt_b = r_gnt_b;

  assign w_xfer_a     = r_gnt_a & req_a;
  assign w_xfer_b     = r_gnt_b & req_b;
  assign w_burst_done = (r_burst == BURST_LAST);

  assign ram_address = r_gnt_a ? addr_a  : (r_gnt_b ? addr_b  : '0);
  assign ram_wdata   = r_gnt_a ? wdata_a : (r_gnt_b ? wdata_b : '0);
  assign ram_in      = (w_xfer_a & we_a)  | (w_xfer_b & we_b);
  assign ram_out     = (w_xfer_a & ~we_a) | (w_xfer_b & ~we_b);
  assign rdata       = ram_out ? ram_rdata : '0;

  // Contention from IDLE goes to whichever master did not own the RAM last.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (req_a && req_b) w_next = r_last_b ? OWN_A : OWN_B;
        else if (req_a)     w_next = OWN_A;
        else if (req_b)     w_next = OWN_B;
      end
      OWN_A: begin
        if (!req_a)                                  w_next = req_b ? OWN_B : IDLE;
        else if (req_b && w_burst_done && !lock_a)   w_next = OWN_B;
      end
      OWN_B: begin
        if (!req_b)                                  w_next = req_a ? OWN_A : IDLE;
        else if (req_a && w_burst_done && !lock_b)   w_next = OWN_A;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_last_b <= 1'b1;
      r_burst  <= '0;
      r_gnt_a  <= 1'b0;
      r_gnt_b  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_gnt_a <= (w_next == OWN_A);
      r_gnt_b <= (w_next == OWN_B);
      if (w_next != r_state)
        r_burst <= '0;
      else if ((w_xfer_a || w_xfer_b) && !w_burst_done)
        r_burst <= r_burst + 1'b1;
      if (w_next == OWN_A && r_state != OWN_A) r_last_b <= 1'b0;
      if (w_next == OWN_B && r_state != OWN_B) r_last_b <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - directed and randomized check of ram_arbiter against an ownership model
module tb_ram_arbiter;

  localparam int MB = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_a = 0, lock_a = 0, we_a = 0;
  logic [15:0] addr_a = 0;
  logic [7:0]  wdata_a = 0;
  logic        req_b = 0, lock_b = 0, we_b = 0;
  logic [15:0] addr_b = 0;
  logic [7:0]  wdata_b = 0;
  logic        gnt_a, gnt_b, ram_in, ram_out;
  logic [7:0]  rdata, ram_wdata, ram_rdata;
  logic [15:0] ram_address;

  logic [7:0] ram_mem [0:65535];
  logic [7:0] ref_mem [0:65535];

  int n_tests = 0;
  int n_fail  = 0;

  // Model: owner 0 = none, 1 = A, 2 = B; run = transfers completed in current grant.
  int m_owner, m_last, m_run;

  ram_arbiter #(.address_width(16), .data_width(8), .max_burst(MB), .burst_width(3)) dut (
    .clock(clock), .reset(reset),
    .req_a(req_a), .lock_a(lock_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a), .gnt_a(gnt_a),
    .req_b(req_b), .lock_b(lock_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b), .gnt_b(gnt_b),
    .rdata(rdata), .ram_address(ram_address), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .ram_in(ram_in), .ram_out(ram_out)
  );

  always #5 clock = ~clock;

  always @(posedge clock) if (ram_in) ram_mem[ram_address] <= ram_wdata;
  assign ram_rdata = ram_mem[ram_address];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = 0;
    m_last  = 2;
    m_run   = 0;
  endtask

  task automatic cyc();
    logic        xfer, we;
    logic [15:0] addr;
    logic [7:0]  wd;
    int          nxt;
    #2;
    xfer = (m_owner == 1 && req_a) || (m_owner == 2 && req_b);
    we   = (m_owner == 1) ? we_a    : we_b;
    addr = (m_owner == 1) ? addr_a  : addr_b;
    wd   = (m_owner == 1) ? wdata_a : wdata_b;
    chk("gnt_a", 32'(gnt_a), 32'(m_owner == 1));
    chk("gnt_b", 32'(gnt_b), 32'(m_owner == 2));
    chk("ram_in", 32'(ram_in), 32'(xfer && we));
    chk("ram_out", 32'(ram_out), 32'(xfer && !we));
    chk("rdata", 32'(rdata), (xfer && !we) ? 32'(ref_mem[addr]) : 32'd0);
    if (m_owner == 0) begin
      chk("idle_addr", 32'(ram_address), 32'd0);
      chk("idle_wdata", 32'(ram_wdata), 32'd0);
    end else if (xfer) begin
      chk("xfer_addr", 32'(ram_address), 32'(addr));
      if (we) chk("xfer_wdata", 32'(ram_wdata), 32'(wd));
    end
    if (xfer && we) ref_mem[addr] = wd;
    nxt = m_owner;
    if (m_owner == 0) begin
      if (req_a && req_b) nxt = (m_last == 1) ? 2 : 1;
      else if (req_a)     nxt = 1;
      else if (req_b)     nxt = 2;
    end else if (m_owner == 1) begin
      if (!req_a)                              nxt = req_b ? 2 : 0;
      else if (req_b && m_run >= MB - 1 && !lock_a) nxt = 2;
    end else begin
      if (!req_b)                              nxt = req_a ? 1 : 0;
      else if (req_a && m_run >= MB - 1 && !lock_b) nxt = 1;
    end
    if (nxt != m_owner) begin
      m_run = 0;
      if (nxt != 0) m_last = nxt;
    end else if (xfer) begin
      m_run++;
    end
    m_owner = nxt;
    @(posedge clock);
    #1;
  endtask

  initial begin
    int n;
    for (int i = 0; i < 65536; i++) begin
      ram_mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    model_reset();
    #12;
    chk("rst_gnt_a", 32'(gnt_a), 0);
    chk("rst_gnt_b", 32'(gnt_b), 0);
    chk("rst_ram_in", 32'(ram_in), 0);
    chk("rst_ram_out", 32'(ram_out), 0);
    reset = 1'b1;
    @(posedge clock); #1;

    // Lone B request
    req_b = 1; addr_b = 16'h1234;
    cyc();
    #1;
    chk("lone_b_gnt", 32'(gnt_b), 1);
    chk("lone_b_addr", 32'(ram_address), 32'h1234);
    req_b = 0;
    cyc();

    // Contention just after reset: A first, then 4-transfer bursts alternate
    reset = 0; #1; reset = 1; model_reset();
    req_a = 1; req_b = 1; addr_a = 16'h0010; addr_b = 16'h0020;
    cyc();
    chk("first_contention_a", 32'(gnt_a), 1);
    n = 0;
    while (gnt_a && n < 20) begin cyc(); n++; end
    chk("burst_a_len", 32'(n), 4);
    chk("burst_a_to_b", 32'(gnt_b), 1);
    n = 0;
    while (gnt_b && n < 20) begin cyc(); n++; end
    chk("burst_b_len", 32'(n), 4);
    chk("burst_b_to_a", 32'(gnt_a), 1);

    // Lock holds A against pending B
    lock_a = 1;
    n = 0;
    for (int i = 0; i < 10; i++) begin cyc(); if (gnt_a) n++; end
    chk("lock_hold", 32'(n), 10);
    req_a = 0;
    cyc();
    chk("release_gnt_b", 32'(gnt_b), 1);
    chk("release_gnt_a", 32'(gnt_a), 0);
    lock_a = 0;

    // A writes 5A to ABCD, B reads it back
    req_b = 0;
    cyc();
    req_a = 1; we_a = 1; addr_a = 16'hABCD; wdata_a = 8'h5A;
    cyc();
    cyc();
    req_a = 0; we_a = 0; req_b = 1; we_b = 0; addr_b = 16'hABCD;
    cyc();
    #1;
    chk("readback_rdata", 32'(rdata), 32'h5A);
    chk("readback_ram_out", 32'(ram_out), 1);

    // Owner with req low and no competitor
    req_b = 0; req_a = 1;
    cyc();
    cyc();
    req_a = 0;
    #1;
    chk("noreq_ram_in", 32'(ram_in), 0);
    chk("noreq_ram_out", 32'(ram_out), 0);
    chk("noreq_gnt_a", 32'(gnt_a), 1);
    cyc();
    chk("noreq_idle", 32'({gnt_a, gnt_b}), 0);

    // Asynchronous reset in the middle of an A write burst
    req_a = 1; we_a = 1; addr_a = 16'h0042; wdata_a = 8'hC3; req_b = 1;
    cyc();
    cyc();
    #1; reset = 0; #1;
    chk("async_gnt_a", 32'(gnt_a), 0);
    chk("async_ram_in", 32'(ram_in), 0);
    model_reset();
    reset = 1;
    cyc();
    chk("post_reset_a", 32'(gnt_a), 1);

    // Randomized traffic on a small address window
    for (int i = 0; i < 600; i++) begin
      req_a   = ($urandom_range(0, 3) != 0);
      req_b   = ($urandom_range(0, 3) != 0);
      lock_a  = ($urandom_range(0, 7) == 0);
      lock_b  = ($urandom_range(0, 7) == 0);
      we_a    = $urandom_range(0, 1) == 1;
      we_b    = $urandom_range(0, 1) == 1;
      addr_a  = 16'($urandom_range(0, 15));
      addr_b  = 16'($urandom_range(0, 15));
      wdata_a = 8'($urandom);
      wdata_b = 8'($urandom);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
